instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Program loader that writes the instruction memory through its debug write port.
- Accepts a byte stream from the debug unit (UART RX side) and packs each group of 4 bytes into a big-endian 32-bit word; the first byte received becomes bits [31:24] and is stored at the lowest byte address.
- Drives word-aligned address, instruction data and a write-enable pulse whose rising edge is the memory's write strobe.
- Stops after writing the HALT word, or flags an error if memory fills before a HALT word arrives.

Parameters:
- NBITS, 8: byte width of the stream and of each memory cell.
- INST_BITS, 32: instruction width; must equal 4*NBITS.
- CELLS, 256: memory size in bytes; must be a multiple of 4.
- HALT_WORD, 32'hFFFFFFFF: end-of-program instruction. It is written to memory, then loading stops.

Ports:
- i_clk  in  1  system clock; all logic is on posedge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse that begins a load at address 0.
- i_byte  in  NBITS  stream data.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader can accept a byte.
- o_dbg_addr  out  INST_BITS  byte address of the word being written.
- o_dbg_inst  out  INST_BITS  packed instruction.
- o_dbg_wr_en  out  1  write strobe; memory captures on its rising edge.
- o_busy  out  1  a load is in progress.
- o_done  out  1  HALT word written; sticky.
- o_error  out  1  memory full without HALT; sticky.
- o_word_count  out  $clog2(CELLS)  number of words written in the current load.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE; every output and internal register = 0.
- All outputs are registered.
- States:
  - IDLE: ready=0, busy=0. On i_start: clear addr, byte_cnt, word_count, done and error; go to RECV.
  - RECV: ready=1, busy=1. A byte is accepted on a posedge with valid && ready. On accept: buf <= {buf[INST_BITS-NBITS-1:0], i_byte}; byte_cnt += 1. Accepting the 4th byte (byte_cnt==3) goes to SETUP. valid with ready=0 is not consumed; the source holds the byte.
  - SETUP: ready=0. o_dbg_addr <= addr; o_dbg_inst <= buf; o_dbg_wr_en stays 0. Go to WRITE.
  - WRITE: o_dbg_wr_en=1 for exactly one cycle; addr and inst are held stable. Go to HOLD.
  - HOLD: o_dbg_wr_en=0; addr and inst still held; word_count += 1; addr += 4; byte_cnt = 0. Next state:
    - buf==HALT_WORD: go to DONE.
    - else if addr+4 == CELLS: go to ERROR.
    - else: go to RECV.
  - DONE: done=1, busy=0, ready=0. i_start restarts the load (as from IDLE).
  - ERROR: error=1, busy=0, ready=0. i_start restarts the load (as from IDLE).
- Timing, with the 4th byte accepted at edge k:
  - o_dbg_addr and o_dbg_inst are valid after edge k+1.
  - o_dbg_wr_en rises after edge k+2 and falls after edge k+3.
  - ready reasserts after edge k+3.
  - Minimum throughput: 7 cycles per word.
- Data and address are never changed while o_dbg_wr_en=1, nor in the cycle before or after it.
- i_start while busy (RECV, SETUP, WRITE or HOLD) is ignored.
- A HALT word written into the last word slot (addr = CELLS-4) goes to DONE, not ERROR. HALT has priority over full.
- Address width: addr is internally $clog2(CELLS)+1 bits and zero-extended to INST_BITS.
- Reset during a partial word discards the collected bytes. Memory is not touched, because o_dbg_wr_en drops to 0 asynchronously.

Test Plan:
- Single word: start, then bytes FF FF FF FF -> one wr_en pulse with addr=0, inst=FFFFFFFF; o_done=1; o_word_count=1; ready stays 0 afterwards.
- Three words: 20 08 00 05, 00 00 00 00, FF FF FF FF -> writes at addr 0, 4, 8 with inst 20080005, 00000000, FFFFFFFF; readback through the memory debug port matches; done=1.
- Backpressure: valid toggled with 0–3 idle cycles between bytes, and valid held high during SETUP/WRITE/HOLD -> no byte lost or duplicated; wr_en is high for exactly 1 cycle per word with addr/inst stable around it.
- Overflow with CELLS=16: 4 non-HALT words -> 4 writes at addr 0–12, then error=1 and done=0. Repeat with the 4th word = HALT -> done=1, error=0.
- Reset mid-word: 2 bytes accepted, then i_rst low for 1 cycle -> all outputs 0, no wr_en pulse; a fresh start then loads correctly from addr 0.
- i_start pulsed during RECV -> ignored: addr and word_count continue unchanged.

Source files
------------

// File: rtl/instruction_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and writes them
// through the instruction memory debug port until a HALT word or memory full.
module instruction_loader #(
    parameter int unsigned NBITS     = 8,
    parameter int unsigned INST_BITS = 32,
    parameter int unsigned CELLS     = 256,
    parameter logic [INST_BITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NBITS-1:0]           i_byte,
    input  logic                       i_byte_valid,
    output logic                       o_byte_ready,
    output logic [INST_BITS-1:0]       o_dbg_addr,
    output logic [INST_BITS-1:0]       o_dbg_inst,
    output logic                       o_dbg_wr_en,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [$clog2(CELLS)-1:0]   o_word_count
);

    localparam int unsigned AW  = $clog2(CELLS) + 1;
    localparam int unsigned WCW = $clog2(CELLS);

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StSetup,
        StWrite,
        StHold,
        StDone,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]         word_count_q, word_count_d;
    logic [INST_BITS-1:0]   buf_q, buf_d;
    logic [INST_BITS-1:0]   dbg_addr_q, dbg_addr_d;
    logic [INST_BITS-1:0]   dbg_inst_q, dbg_inst_d;
    logic                   wr_en_q, wr_en_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   accept;
    logic [AW-1:0]          addr_next;

    // ready_q is only ever high in StRecv, so it alone qualifies a byte
    assign accept    = ready_q & i_byte_valid;
    assign addr_next = addr_q + AW'(4);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        word_count_d = word_count_q;
        buf_d        = buf_q;
        dbg_addr_d   = dbg_addr_q;
        dbg_inst_d   = dbg_inst_q;
        done_d       = done_q;
        error_d      = error_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (i_start) begin
                    addr_d       = '0;
                    byte_cnt_d   = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    state_d      = StRecv;
                end
            end
            StRecv: begin
                if (accept) begin
                    buf_d      = {buf_q[INST_BITS-NBITS-1:0], i_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                dbg_addr_d = {{(INST_BITS-AW){1'b0}}, addr_q};
                dbg_inst_d = buf_q;
                state_d    = StWrite;
            end
            StWrite: begin
                state_d = StHold;
            end
            StHold: begin
                word_count_d = word_count_q + WCW'(1);
                addr_d       = addr_next;
                byte_cnt_d   = '0;
                // HALT wins over a full memory
                if (buf_q == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (addr_next == AW'(CELLS)) begin
                    error_d = 1'b1;
                    state_d = StError;
                end else begin
                    state_d = StRecv;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobe lags the WRITE state by one register so addr/inst settle a cycle first
        wr_en_d = (state_q == StWrite);
        ready_d = (state_d == StRecv);
        busy_d  = (state_d == StRecv) || (state_d == StSetup) ||
                  (state_d == StWrite) || (state_d == StHold);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            word_count_q <= '0;
            buf_q        <= '0;
            dbg_addr_q   <= '0;
            dbg_inst_q   <= '0;
            wr_en_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_count_q <= word_count_d;
            buf_q        <= buf_d;
            dbg_addr_q   <= dbg_addr_d;
            dbg_inst_q   <= dbg_inst_d;
            wr_en_q      <= wr_en_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_dbg_addr   = dbg_addr_q;
    assign o_dbg_inst   = dbg_inst_q;
    assign o_dbg_wr_en  = wr_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a 16-byte memory model on the debug port.
module tb_instruction_loader;

    localparam int unsigned CELLS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_inst;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4];
    logic [31:0] pa [64];
    logic [31:0] pi [64];
    int          pn = 0;

    logic        p1_we = 1'b0, p2_we = 1'b0;
    logic [31:0] p1_addr = '0, p2_addr = '0, p1_inst = '0, p2_inst = '0;

    instruction_loader #(
        .NBITS(8),
        .INST_BITS(32),
        .CELLS(CELLS),
        .HALT_WORD(32'hFFFFFFFF)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_byte(byte_in),
        .i_byte_valid(valid),
        .o_byte_ready(ready),
        .o_dbg_addr(dbg_addr),
        .o_dbg_inst(dbg_inst),
        .o_dbg_wr_en(wr_en),
        .o_busy(busy),
        .o_done(done),
        .o_error(error),
        .o_word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge wr_en) mem[dbg_addr[3:2]] <= dbg_inst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Pulse log plus one-cycle-wide and stable-around-strobe checks
    always @(negedge clk) begin
        if (wr_en) begin
            pa[pn] = dbg_addr;
            pi[pn] = dbg_inst;
            pn++;
        end
        if (p1_we) begin
            check("wr_en_width_stable",
                  {31'd0, !p2_we && !wr_en && p2_addr == p1_addr && dbg_addr == p1_addr &&
                   p2_inst == p1_inst && dbg_inst == p1_inst}, 32'd1);
        end
        p2_we   <= p1_we;
        p2_addr <= p1_addr;
        p2_inst <= p1_inst;
        p1_we   <= wr_en;
        p1_addr <= dbg_addr;
        p1_inst <= dbg_inst;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   n;
        if (gap > 0) begin
            valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        byte_in = b;
        valid   = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 0);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", {31'd0, n < 200}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_addr"}, dbg_addr, 32'd0);
        check({tag, "_inst"}, dbg_inst, 32'd0);
        check({tag, "_wc"}, {28'd0, word_count}, 32'd0);
    endtask

    initial begin
        int   base;
        logic [7:0] bp [12];

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single HALT word
        pulse_start();
        check("t1_ready_after_start", {31'd0, ready}, 32'd1);
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        send_word(32'hFFFFFFFF);
        valid = 1'b0;
        wait_end();
        check("t1_pulses", pn, 32'd1);
        check("t1_addr", pa[0], 32'd0);
        check("t1_inst", pi[0], 32'hFFFFFFFF);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_wc", {28'd0, word_count}, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("t1_ready_after", {31'd0, ready}, 32'd0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Three words with cycle-exact timing on the first
        base = pn;
        pulse_start();
        check("t2_done_cleared", {31'd0, done}, 32'd0);
        send_word(32'h20080005);
        valid = 1'b0;
        check("t2_k_wr_en", {31'd0, wr_en}, 32'd0);
        check("t2_k_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1 check("t2_k1_addr", dbg_addr, 32'd0);
        check("t2_k1_inst", dbg_inst, 32'h20080005);
        check("t2_k1_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk);
        #1 check("t2_k2_wr_en", {31'd0, wr_en}, 32'd1);
        @(posedge clk);
        #1 check("t2_k3_wr_en", {31'd0, wr_en}, 32'd0);
        check("t2_k3_ready", {31'd0, ready}, 32'd1);
        check("t2_k3_wc", {28'd0, word_count}, 32'd1);
        send_word(32'h00000000);
        send_word(32'hFFFFFFFF);
        valid = 1'b0;
        wait_end();
        check("t2_pulses", pn - base, 32'd3);
        check("t2_addr1", pa[base+1], 32'd4);
        check("t2_addr2", pa[base+2], 32'd8);
        check("t2_mem0", mem[0], 32'h20080005);
        check("t2_mem1", mem[1], 32'h00000000);
        check("t2_mem2", mem[2], 32'hFFFFFFFF);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_wc", {28'd0, word_count}, 32'd3);

        // Backpressure: 0..3 idle cycles, valid held across SETUP/WRITE/HOLD on gap 0
        bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
        base = pn;
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(bp[i], i % 4);
        valid = 1'b0;
        wait_end();
        check("t3_pulses", pn - base, 32'd3);
        check("t3_inst0", pi[base], 32'h11223344);
        check("t3_inst1", pi[base+1], 32'h55667788);
        check("t3_inst2", pi[base+2], 32'hFFFFFFFF);
        check("t3_addr2", pa[base+2], 32'd8);
        check("t3_wc", {28'd0, word_count}, 32'd3);

        // Overflow: four non-HALT words fill 16 bytes
        base = pn;
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 0);
        valid = 1'b0;
        wait_end();
        check("t4_pulses", pn - base, 32'd4);
        check("t4_addr3", pa[base+3], 32'd12);
        check("t4_inst3", pi[base+3], 32'h0D0E0F10);
        check("t4_error", {31'd0, error}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_wc", {28'd0, word_count}, 32'd4);
        check("t4_ready", {31'd0, ready}, 32'd0);

        // HALT in the last slot wins over full
        base = pn;
        pulse_start();
        check("t5_error_cleared", {31'd0, error}, 32'd0);
        for (int i = 0; i < 12; i++) send_byte(8'(i + 1), 0);
        send_word(32'hFFFFFFFF);
        valid = 1'b0;
        wait_end();
        check("t5_pulses", pn - base, 32'd4);
        check("t5_addr3", pa[base+3], 32'd12);
        check("t5_mem3", mem[3], 32'hFFFFFFFF);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_error", {31'd0, error}, 32'd0);
        check("t5_wc", {28'd0, word_count}, 32'd4);

        // Reset after two bytes of a word
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        valid = 1'b0;
        base = pn;
        rst = 1'b0;
        #1 check_all_zero("t6_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("t6_no_pulse", pn - base, 32'd0);
        pulse_start();
        send_word(32'hA1B2C3D4);
        send_word(32'hFFFFFFFF);
        valid = 1'b0;
        wait_end();
        check("t6_addr0", pa[base], 32'd0);
        check("t6_inst0", pi[base], 32'hA1B2C3D4);
        check("t6_wc", {28'd0, word_count}, 32'd2);
        check("t6_done", {31'd0, done}, 32'd1);

        // Start during RECV is ignored
        base = pn;
        pulse_start();
        send_word(32'h12345678);
        send_byte(8'h9A, 0);
        valid = 1'b0;
        pulse_start();
        check("t7_wc_mid", {28'd0, word_count}, 32'd1);
        check("t7_busy_mid", {31'd0, busy}, 32'd1);
        send_byte(8'hBC, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hF0, 0);
        send_word(32'hFFFFFFFF);
        valid = 1'b0;
        wait_end();
        check("t7_pulses", pn - base, 32'd3);
        check("t7_addr1", pa[base+1], 32'd4);
        check("t7_inst1", pi[base+1], 32'h9ABCDEF0);
        check("t7_addr2", pa[base+2], 32'd8);
        check("t7_wc", {28'd0, word_count}, 32'd3);
        check("t7_done", {31'd0, done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
